// File: rtl/sejf_pkg.sv
// Shared definitions for the safe's counter blocks: digit width, digit
// extraction from a packed vector and load-value clamping.
package sejf_pkg;

  localparam int DIGIT_W = 4;

  function automatic logic [DIGIT_W-1:0] dig_sel(input logic [31:0] vec, input int idx);
    return vec[idx*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d, input int radix);
    if (int'(d) > radix - 1)
      return DIGIT_W'(radix - 1);
    return d;
  endfunction

endpackage

// File: rtl/bcd_cnt_ndig_if.sv
// Control and status bundle of the multi-digit counter.
interface bcd_cnt_ndig_if #(parameter int DIGITS = 4) ();
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   cnt;
  logic                  wrap;
  logic                  sat;
  logic                  zero;
  logic                  at_max;

  modport master (output en, up, load, load_val,
                  input  cnt, wrap, sat, zero, at_max);
  modport slave  (input  en, up, load, load_val,
                  output cnt, wrap, sat, zero, at_max);
endinterface

// File: rtl/bcd_digit.sv
// One radix-RADIX counter cell; steps when step_in is high and reports a
// carry/borrow when it rolls past its end.
module bcd_digit
  import sejf_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_digit,
  input  logic               step_in,
  input  logic               up,
  output logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] digit_nxt,
  output logic               carry_out
);

  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(RADIX - 1);

  always_comb begin
    digit_nxt = digit;
    if (load)
      digit_nxt = ld_digit;
    else if (step_in) begin
      if (up)
        digit_nxt = (digit == DMAX) ? '0 : digit + 1'b1;
      else
        digit_nxt = (digit == '0) ? DMAX : digit - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      digit <= '0;
    else
      digit <= digit_nxt;
  end

  assign carry_out = step_in & (up ? (digit == DMAX) : (digit == '0));

endmodule

// File: rtl/bcd_cnt_ndig.sv
// Multi-digit radix-N up/down counter with parallel load and wrap or
// saturate behaviour at the ends of the range.
module bcd_cnt_ndig
  import sejf_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int WRAP   = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_cnt_ndig_if.slave  bus
);

  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(RADIX - 1);

  logic [DIGITS-1:0]         step;
  logic [DIGITS-1:0]         carry;
  logic [DIGIT_W*DIGITS-1:0] cnt_q;
  logic [DIGIT_W*DIGITS-1:0] cnt_nxt;
  logic all_max, all_zero, nxt_max, nxt_zero;
  logic eor, blocked;
  logic wrap_q, sat_q, zero_q, at_max_q;

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    nxt_max  = 1'b1;
    nxt_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_max  &= (dig_sel(32'(cnt_q), i) == DMAX);
      all_zero &= (dig_sel(32'(cnt_q), i) == '0);
      nxt_max  &= (dig_sel(32'(cnt_nxt), i) == DMAX);
      nxt_zero &= (dig_sel(32'(cnt_nxt), i) == '0);
    end
  end

  // End-of-range is detected from the digits directly so that blocking the
  // first step in saturate mode does not feed back through the carry chain.
  assign eor     = bus.up ? all_max : all_zero;
  assign blocked = (WRAP == 0) && eor;
  assign step[0] = bus.en & ~bus.load & ~blocked;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g > 0) begin : g_chain
      assign step[g] = carry[g-1];
    end
    bcd_digit #(.RADIX(RADIX)) u_digit (
      .clk       (clk),
      .rst       (rst),
      .load      (bus.load),
      .ld_digit  (clamp_digit(dig_sel(32'(bus.load_val), g), RADIX)),
      .step_in   (step[g]),
      .up        (bus.up),
      .digit     (cnt_q[g*DIGIT_W +: DIGIT_W]),
      .digit_nxt (cnt_nxt[g*DIGIT_W +: DIGIT_W]),
      .carry_out (carry[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_q   <= 1'b0;
      sat_q    <= 1'b0;
      zero_q   <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      wrap_q   <= carry[DIGITS-1];
      sat_q    <= bus.en & ~bus.load & blocked;
      zero_q   <= nxt_zero;
      at_max_q <= nxt_max;
    end
  end

  assign bus.cnt    = cnt_q;
  assign bus.wrap   = wrap_q;
  assign bus.sat    = sat_q;
  assign bus.zero   = zero_q;
  assign bus.at_max = at_max_q;

endmodule
